adc128s052_responder: RTL and testbench

//  Synthesizable responder (slave) end of the ADC128S052 serial link: emulates the ADC chip.

---
 rtl/adc128_pkg.sv | 17 +
 rtl/adc_sample_bank.sv | 52 +++++
 rtl/adc128s052_responder.sv | 126 ++++++++++++
 tb/tb_adc128s052_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adc128_pkg.sv
// Shared constants and types for the ADC128S052 serial link.
// Used by both the responder (chip model) and the tape ADC master.
package adc128_pkg;

  localparam int FRAME_LEN       = 16;
  localparam int DATA_W          = 12;
  localparam int NUM_CH          = 8;
  localparam int ADDR_W          = 3;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int SNAPSHOT_EDGE   = 4;

  localparam logic [DATA_W-1:0] RESET_SAMPLE = 12'h800;

  typedef logic [ADDR_W-1:0] adc_ch_t;
  typedef logic [DATA_W-1:0] adc_sample_t;

endpackage

// File: rtl/adc_sample_bank.sv
// Per-channel sample registers: posedge write port, combinational read port.
// Reset loads every entry with the mid-scale value.
module adc_sample_bank #(
  parameter int                NUM_CH       = 8,
  parameter int                DATA_W       = 12,
  parameter logic [DATA_W-1:0] RESET_SAMPLE = 12'h800
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data
);

  logic [NUM_CH-1:0][DATA_W-1:0] bank_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_entry
      logic [DATA_W-1:0] sample_q;
      logic [DATA_W-1:0] sample_d;

      // Channel numbers beyond NUM_CH never match, so such writes fall away.
      always_comb begin
        sample_d = sample_q;
        if (wr_en && (wr_ch == 3'(gi))) begin
          sample_d = wr_data;
        end
      end

      always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
          sample_q <= RESET_SAMPLE;
        end else begin
          sample_q <= sample_d;
        end
      end

      assign bank_vec[gi] = sample_q;
    end
  endgenerate

  always_comb begin
    rd_data = RESET_SAMPLE;
    if (32'(rd_ch) < NUM_CH) begin
      rd_data = bank_vec[rd_ch];
    end
  end

endmodule

// File: rtl/adc128s052_responder.sv
// ADC128S052 chip model: address decoded on rising sclk, sample shifted out on falling sclk.
// Each frame returns the channel addressed in the previous frame.
module adc128s052_responder #(
  parameter int                NUM_CH       = adc128_pkg::NUM_CH,
  parameter int                DATA_W       = adc128_pkg::DATA_W,
  parameter int                FRAME_LEN    = adc128_pkg::FRAME_LEN,
  parameter logic [DATA_W-1:0] RESET_SAMPLE = adc128_pkg::RESET_SAMPLE
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                csn,
  input  logic                din,
  output logic                dout,
  output logic                dout_oe,
  input  logic                wr_en,
  input  logic [2:0]          wr_ch,
  input  logic [DATA_W-1:0]   wr_data,
  output adc128_pkg::adc_ch_t conv_ch,
  output logic                frame_done
);

  import adc128_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN);
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter value held just before edge n is n-1 (edge FRAME_LEN wraps to 0).
  localparam cnt_t LAST_CNT   = cnt_t'(FRAME_LEN - 1);
  localparam cnt_t ADDR_LO    = cnt_t'(ADDR_FIRST_EDGE - 1);
  localparam cnt_t ADDR_HI    = cnt_t'(ADDR_FIRST_EDGE + ADDR_W - 2);
  localparam cnt_t SNAP_CNT   = cnt_t'(SNAPSHOT_EDGE - 1);
  localparam cnt_t SHIFT_LAST = cnt_t'(SNAPSHOT_EDGE + DATA_W - 2);

  cnt_t        rise_cnt_q, rise_cnt_d;
  adc_ch_t     addr_q, addr_d;
  adc_ch_t     next_ch_q, next_ch_d;
  adc_ch_t     conv_ch_q, conv_ch_d;
  logic        frame_done_q, frame_done_d;
  cnt_t        fall_cnt_q, fall_cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] bank_rd;

  adc_sample_bank #(
    .NUM_CH       (NUM_CH),
    .DATA_W       (DATA_W),
    .RESET_SAMPLE (RESET_SAMPLE)
  ) u_bank (
    .sclk    (sclk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .rd_ch   (conv_ch_q),
    .rd_data (bank_rd)
  );

  always_comb begin
    rise_cnt_d   = rise_cnt_q + 1'b1;
    addr_d       = addr_q;
    next_ch_d    = next_ch_q;
    conv_ch_d    = conv_ch_q;
    frame_done_d = 1'b0;
    if ((rise_cnt_q >= ADDR_LO) && (rise_cnt_q <= ADDR_HI)) begin
      addr_d = {addr_q[ADDR_W-2:0], din};
    end
    if (rise_cnt_q == '0) begin
      conv_ch_d = next_ch_q;
    end
    if (rise_cnt_q == LAST_CNT) begin
      next_ch_d    = addr_q;
      conv_ch_d    = addr_q;
      frame_done_d = 1'b1;
      addr_d       = '0;
    end
  end

  // Frame position and partial address are dropped whenever csn goes high.
  always_ff @(posedge sclk or posedge rst or posedge csn) begin
    if (rst || csn) begin
      rise_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      next_ch_q    <= '0;
      conv_ch_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      next_ch_q    <= next_ch_d;
      conv_ch_q    <= conv_ch_d;
      frame_done_q <= frame_done_d;
    end
  end

  // tx MSB drives dout directly; the register is zero outside the data window.
  always_comb begin
    fall_cnt_d = fall_cnt_q + 1'b1;
    tx_d       = '0;
    if (fall_cnt_q == SNAP_CNT) begin
      tx_d = bank_rd;
    end else if ((fall_cnt_q > SNAP_CNT) && (fall_cnt_q <= SHIFT_LAST)) begin
      tx_d = tx_q << 1;
    end
  end

  always_ff @(negedge sclk or posedge rst or posedge csn) begin
    if (rst || csn) begin
      fall_cnt_q <= '0;
      tx_q       <= '0;
    end else begin
      fall_cnt_q <= fall_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign dout       = tx_q[DATA_W-1];
  assign dout_oe    = ~csn & ~rst;
  assign conv_ch    = conv_ch_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_adc128s052_responder.sv
// Directed bench for the ADC128S052 responder: the bench plays the master,
// sampling dout just before each rising sclk edge.
module tb_adc128s052_responder;

  logic        sclk = 1'b0;
  logic        rst;
  logic        csn;
  logic        din;
  logic        dout;
  logic        dout_oe;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic [2:0]  conv_ch;
  logic        frame_done;

  int checks = 0;
  int passes = 0;

  adc128s052_responder dut (
    .sclk       (sclk),
    .rst        (rst),
    .csn        (csn),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .conv_ch    (conv_ch),
    .frame_done (frame_done)
  );

  always #5 sclk = ~sclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed %h required %h", tag, observed, expected);
  endtask

  task automatic next_cycle();
    @(posedge sclk);
    @(negedge sclk);
    #1;
  endtask

  task automatic bank_write(input logic [2:0] ch, input logic [11:0] data);
    wr_ch   = ch;
    wr_data = data;
    wr_en   = 1'b1;
    next_cycle();
    wr_en = 1'b0;
    $display("write bank[%0d] = %h", ch, data);
  endtask

  // Runs rising edges 1..stop_at of a frame; non-address din slots carry 1s.
  task automatic run_frame(input logic [2:0] addr, input int stop_at, input int wr_at,
                           input logic [11:0] wdat, output logic [15:0] rx,
                           output int dones, output int done_pos);
    rx = '0;
    dones = 0;
    done_pos = 0;
    for (int n = 1; n <= stop_at; n++) begin
      din = (n == 3) ? addr[2] : (n == 4) ? addr[1] : (n == 5) ? addr[0] : 1'b1;
      wr_en   = (n == wr_at);
      wr_ch   = 3'd3;
      wr_data = wdat;
      rx = {rx[14:0], dout};
      next_cycle();
      wr_en = 1'b0;
      if (frame_done) begin
        dones++;
        done_pos = n;
      end
    end
  endtask

  task automatic full_frame(input int idx, input logic [2:0] addr, input int wr_at,
                            input logic [11:0] wdat, input logic [15:0] exp_rx,
                            input logic [2:0] exp_ch);
    logic [15:0] rx;
    int dones;
    int pos;
    run_frame(addr, 16, wr_at, wdat, rx, dones, pos);
    $display("frame %0d addr %0d rx %h conv_ch %0d frame_done x%0d at edge %0d",
             idx, addr, rx, conv_ch, dones, pos);
    check($sformatf("frame%0d_rx", idx), rx, exp_rx);
    check($sformatf("frame%0d_conv_ch", idx), 16'(conv_ch), 16'(exp_ch));
    check($sformatf("frame%0d_done_count", idx), 16'(dones), 16'd1);
    check($sformatf("frame%0d_done_edge", idx), 16'(pos), 16'd16);
  endtask

  initial begin
    logic [15:0] rx;
    int dones;
    int pos;

    rst = 1'b1;
    csn = 1'b1;
    din = 1'b0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_data = '0;
    @(negedge sclk);
    #1;
    check("reset_dout", 16'(dout), 16'd0);
    check("reset_dout_oe", 16'(dout_oe), 16'd0);
    check("reset_conv_ch", 16'(conv_ch), 16'd0);
    check("reset_frame_done", 16'(frame_done), 16'd0);
    rst = 1'b0;
    next_cycle();

    bank_write(3'd0, 12'hABC);
    bank_write(3'd5, 12'h5A5);
    bank_write(3'd1, 12'h100);
    bank_write(3'd2, 12'h200);
    bank_write(3'd3, 12'h300);
    bank_write(3'd4, 12'hFFF);

    csn = 1'b0;
    #1;
    check("csn_low_dout_oe", 16'(dout_oe), 16'd1);
    check("csn_low_dout", 16'(dout), 16'd0);

    // Pipelined address: each frame returns the previous frame's channel.
    full_frame(1, 3'd5, 0, 12'h000, 16'h0ABC, 3'd5);
    full_frame(2, 3'd1, 0, 12'h000, 16'h05A5, 3'd1);
    full_frame(3, 3'd2, 0, 12'h000, 16'h0100, 3'd2);
    full_frame(4, 3'd3, 0, 12'h000, 16'h0200, 3'd3);
    // Write at rising 4 lands before the snapshot; at rising 6 it lands after.
    full_frame(5, 3'd3, 4, 12'hFFF, 16'h0FFF, 3'd3);
    full_frame(6, 3'd3, 4, 12'h300, 16'h0300, 3'd3);
    full_frame(7, 3'd3, 6, 12'hFFF, 16'h0300, 3'd3);
    full_frame(8, 3'd1, 0, 12'h000, 16'h0FFF, 3'd1);

    // Abort a frame addressing channel 6 after rising edge 4.
    run_frame(3'd6, 4, 0, 12'h000, rx, dones, pos);
    csn = 1'b1;
    #1;
    $display("frame 9 addr 6 aborted after edge 4, dout %0b dout_oe %0b", dout, dout_oe);
    check("abort_dout", 16'(dout), 16'd0);
    check("abort_dout_oe", 16'(dout_oe), 16'd0);
    check("abort_done_in_frame", 16'(dones), 16'd0);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      if (frame_done) dones++;
    end
    check("abort_done_idle", 16'(dones), 16'd0);
    check("abort_conv_ch", 16'(conv_ch), 16'd1);
    csn = 1'b0;
    full_frame(10, 3'd4, 0, 12'h000, 16'h0100, 3'd4);

    // Reset in the middle of a frame that is shifting out bank[4] = FFF.
    run_frame(3'd5, 6, 0, 12'h000, rx, dones, pos);
    $display("frame 11 addr 5 cut by rst after edge 6, rx %h dout %0b", rx, dout);
    check("prerst_rx", rx, 16'h0003);
    check("prerst_dout", 16'(dout), 16'd1);
    rst = 1'b1;
    #1;
    check("midrst_dout", 16'(dout), 16'd0);
    check("midrst_dout_oe", 16'(dout_oe), 16'd0);
    check("midrst_conv_ch", 16'(conv_ch), 16'd0);
    check("midrst_frame_done", 16'(frame_done), 16'd0);
    csn = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    csn = 1'b0;
    full_frame(12, 3'd5, 0, 12'h000, 16'h0800, 3'd5);
    full_frame(13, 3'd0, 0, 12'h000, 16'h0800, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
